// File: rtl/ex_div_pkg.sv
// Shared definitions for the EX-stage iterative divider: FSM state
// encodings, handshake level names and the default operand width.
package ex_div_pkg;

  localparam int DivWidth = 32;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

endpackage

// File: rtl/ex_div.sv
// ex_div: iterative restoring divider for the EX stage, one quotient bit
// per clock. ready_o stays low until result_o = {remainder, quotient} is
// valid so EX can hold its stall request meanwhile.
// Optional feature: define DIV_SIGNED_EN to build signed (DIV) support;
// without it every operation is unsigned and signed_div_i is ignored.
module ex_div
  import ex_div_pkg::*;
#(
  parameter int WIDTH = DivWidth
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntDone = CntW'(WIDTH);

  div_state_e       state;
  logic [CntW-1:0]  cnt;
  logic [2*WIDTH:0] work;
  logic [WIDTH-1:0] divisor_abs;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] dividend_in;
  logic [WIDTH-1:0] divisor_in;
  logic [WIDTH-1:0] quotient_fin;
  logic [WIDTH-1:0] remainder_fin;

  // Trial subtraction of the divisor from the current partial remainder;
  // the top bit set means the divisor did not fit this step.
  assign diff = {1'b0, work[2*WIDTH-1:WIDTH]} - {1'b0, divisor_abs};

`ifdef DIV_SIGNED_EN
  logic quot_neg;
  logic rem_neg;

  // Magnitudes of the operands at acceptance, and sign fix-up of the raw
  // unsigned result at finalize (quotient by sign mismatch, remainder
  // follows the dividend).
  always_comb begin
    dividend_in   = (signed_div_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
    divisor_in    = (signed_div_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + 1'b1) : opdata2_i;
    quotient_fin  = quot_neg ? (~work[WIDTH-1:0] + 1'b1) : work[WIDTH-1:0];
    remainder_fin = rem_neg ? (~work[2*WIDTH:WIDTH+1] + 1'b1) : work[2*WIDTH:WIDTH+1];
  end
`else
  logic unused_signed;

  // Unsigned-only build: operands and raw result pass straight through.
  always_comb begin
    dividend_in   = opdata1_i;
    divisor_in    = opdata2_i;
    quotient_fin  = work[WIDTH-1:0];
    remainder_fin = work[2*WIDTH:WIDTH+1];
  end

  assign unused_signed = signed_div_i;
`endif

  // Divider FSM: accept, iterate one restoring step per edge, finalize,
  // then hold the result until EX drops start_i; annul aborts anywhere.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= DivFree;
      cnt         <= '0;
      work        <= '0;
      divisor_abs <= '0;
      result_o    <= '0;
      ready_o     <= DivResultNotReady;
`ifdef DIV_SIGNED_EN
      quot_neg    <= 1'b0;
      rem_neg     <= 1'b0;
`endif
    end else if (annul_i) begin
      state    <= DivFree;
      cnt      <= '0;
      result_o <= '0;
      ready_o  <= DivResultNotReady;
    end else begin
      case (state)
        DivFree: begin
          result_o <= '0;
          ready_o  <= DivResultNotReady;
          if (start_i == DivStart) begin
            if (opdata2_i == '0) begin
              state <= DivByZero;
            end else begin
              state       <= DivOn;
              cnt         <= '0;
              work        <= {{WIDTH{1'b0}}, dividend_in, 1'b0};
              divisor_abs <= divisor_in;
`ifdef DIV_SIGNED_EN
              quot_neg    <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
              rem_neg     <= signed_div_i & opdata1_i[WIDTH-1];
`endif
            end
          end
        end
        DivByZero: begin
          state    <= DivEnd;
          result_o <= '0;
          ready_o  <= DivResultReady;
        end
        DivOn: begin
          if (cnt != CntDone) begin
            if (diff[WIDTH]) begin
              work <= {work[2*WIDTH-1:0], 1'b0};
            end else begin
              work <= {diff[WIDTH-1:0], work[WIDTH-1:0], 1'b1};
            end
            cnt <= cnt + 1'b1;
          end else begin
            state    <= DivEnd;
            cnt      <= '0;
            result_o <= {remainder_fin, quotient_fin};
            ready_o  <= DivResultReady;
          end
        end
        DivEnd: begin
          if (start_i == DivStop) begin
            state    <= DivFree;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
          end
        end
        default: begin
          state <= DivFree;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_div.sv
// Testbench for ex_div: directed cases plus randomized operations, all
// compared against a plain-arithmetic divide model.
module tb_ex_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int checks = 0;
  int errors = 0;

  ex_div dut (
    .clk         (clk),
    .rst         (rst),
    .signed_div_i(signed_div_i),
    .opdata1_i   (opdata1_i),
    .opdata2_i   (opdata2_i),
    .start_i     (start_i),
    .annul_i     (annul_i),
    .result_o    (result_o),
    .ready_o     (ready_o)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Reference model: {remainder, quotient}, truncating division, zero on
  // a zero divisor; signed semantics only when the signed build is used.
  function automatic logic [63:0] refDiv(input logic [31:0] a, input logic [31:0] b,
                                         input bit sgn);
    bit     use_signed;
    longint sa, sb, q, r;
`ifdef DIV_SIGNED_EN
    use_signed = sgn;
`else
    use_signed = sgn & 1'b0;
`endif
    if (b == 32'd0) return 64'd0;
    if (use_signed) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  // Single comparison point: counts every check, reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation: launch, wait for ready with a cycle budget, check
  // latency and result, optionally hold start, then release and check clear.
  task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [31:0] b,
                               input bit sgn, input logic [63:0] expected,
                               input int holdCycles, input int dropAt, input bit scramble);
    int n;
    bit got;
    int lat;
    lat          = (b == 32'd0) ? 1 : 33;
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    tick();
    n   = 0;
    got = 1'b0;
    while (!got && n < 100) begin
      if (scramble) begin
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = 1'($urandom_range(0, 1));
      end
      if (n == dropAt) start_i = 1'b0;
      tick();
      n++;
      if (ready_o) got = 1'b1;
    end
    checkOutput({tag, " latency"}, 64'(n), 64'(lat));
    checkOutput({tag, " result"}, result_o, expected);
    if (start_i) begin
      for (int i = 0; i < holdCycles; i++) begin
        tick();
        checkOutput({tag, " hold ready"}, 64'(ready_o), 64'd1);
        checkOutput({tag, " hold result"}, result_o, expected);
      end
    end
    start_i = 1'b0;
    tick();
    checkOutput({tag, " clear ready"}, 64'(ready_o), 64'd0);
    checkOutput({tag, " clear result"}, result_o, 64'd0);
  endtask

  // Wait a number of edges and count how often ready_o was seen high.
  task automatic countReady(input int cycles, output int seen);
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (ready_o) seen++;
    end
  endtask

  logic [63:0] expSigned1;
  logic [63:0] expSigned2;

  // Main sequence.
  initial begin
    int          seen;
    logic [31:0] a;
    logic [31:0] b;
    bit          sgn;

`ifdef DIV_SIGNED_EN
    expSigned1 = {32'hFFFFFFFF, 32'hFFFFFFFD};
    expSigned2 = {32'h00000000, 32'h80000000};
`else
    expSigned1 = {32'h00000001, 32'h7FFFFFFC};
    expSigned2 = {32'h80000000, 32'h00000000};
`endif

    rst          = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    #2 rst = 1'b0;
    #1;
    checkOutput("reset ready", 64'(ready_o), 64'd0);
    checkOutput("reset result", result_o, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    tick();

    applyStimulus("udiv 100/7", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 5, -1, 1'b0);
    applyStimulus("sdiv -7/2", 32'hFFFFFFF9, 32'd2, 1'b1, expSigned1, 0, -1, 1'b0);
    applyStimulus("sdiv min/-1", 32'h80000000, 32'hFFFFFFFF, 1'b1, expSigned2, 0, -1, 1'b0);
    applyStimulus("div by zero", 32'h12345678, 32'd0, 1'b0, 64'd0, 2, -1, 1'b0);
    applyStimulus("start drop", 32'd1000, 32'd33, 1'b0, {32'd10, 32'd30}, 0, 5, 1'b0);
    applyStimulus("operand change", 32'hFFFFFFF0, 32'h10, 1'b0, {32'd0, 32'h0FFFFFFF}, 0, -1, 1'b1);

    // Annul at iteration 10, then annul held together with start.
    opdata1_i = 32'h12345678;
    opdata2_i = 32'd3;
    start_i   = 1'b1;
    tick();
    repeat (10) tick();
    annul_i = 1'b1;
    tick();
    checkOutput("annul ready", 64'(ready_o), 64'd0);
    checkOutput("annul result", result_o, 64'd0);
    repeat (3) tick();
    annul_i = 1'b0;
    start_i = 1'b0;
    countReady(40, seen);
    checkOutput("annul no ready", 64'(seen), 64'd0);
    applyStimulus("after annul", 32'hFFFFFFFF, 32'd1, 1'b0, {32'd0, 32'hFFFFFFFF}, 0, -1, 1'b0);

    // Annul while the result is held clears nonzero outputs.
    opdata1_i = 32'd77;
    opdata2_i = 32'd5;
    start_i   = 1'b1;
    repeat (40) tick();
    checkOutput("end ready", 64'(ready_o), 64'd1);
    annul_i = 1'b1;
    tick();
    checkOutput("end annul ready", 64'(ready_o), 64'd0);
    checkOutput("end annul result", result_o, 64'd0);
    annul_i = 1'b0;
    start_i = 1'b0;
    tick();

    // Asynchronous reset mid-iteration.
    opdata1_i = 32'hDEADBEEF;
    opdata2_i = 32'h1234;
    start_i   = 1'b1;
    tick();
    repeat (15) tick();
    #2 rst = 1'b0;
    start_i = 1'b0;
    #1;
    checkOutput("async rst on ready", 64'(ready_o), 64'd0);
    checkOutput("async rst on result", result_o, 64'd0);
    tick();
    rst = 1'b1;
    countReady(40, seen);
    checkOutput("rst no ready", 64'(seen), 64'd0);

    // Asynchronous reset while a nonzero result is held.
    opdata1_i = 32'd500;
    opdata2_i = 32'd7;
    start_i   = 1'b1;
    repeat (40) tick();
    checkOutput("held result", result_o, {32'd3, 32'd71});
    #2 rst = 1'b0;
    #1;
    checkOutput("async rst end ready", 64'(ready_o), 64'd0);
    checkOutput("async rst end result", result_o, 64'd0);
    start_i = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    applyStimulus("after reset", 32'hDEADBEEF, 32'h1234, 1'b0,
                  refDiv(32'hDEADBEEF, 32'h1234, 1'b0), 0, -1, 1'b0);

    // Randomized operations against the reference model.
    for (int k = 0; k < 24; k++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1, 2:    b = 32'($urandom_range(1, 16));
        3:       b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      if (k % 5 == 0) a = 32'h80000000;
      applyStimulus("random", a, b, sgn, refDiv(a, b, sgn), k % 3, -1, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_div.md
# ex_div

Iterative 32-bit integer divider in the EX stage. Accepts DIV/DIVU operands from the EX stage and computes one quotient bit per cycle. Holds `ready_o` low until the result is available, so the EX stage can raise its stall request into the pipeline's 6-bit stall vector. This keeps the ID/EX register frozen while EX is busy. It is the consumer of the operands the ID/EX register launches, and the producer of the EX-side stall request.

## Interface
Parameters:
- `WIDTH`, default 32: operand width. The result is 2×`WIDTH` bits.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `signed_div_i`  in  1  1 = signed (DIV), 0 = unsigned (DIVU).
- `opdata1_i`  in  WIDTH  dividend.
- `opdata2_i`  in  WIDTH  divisor.
- `start_i`  in  1  request; held high by EX for the whole operation.
- `annul_i`  in  1  abort the current operation (exception/flush).
- `result_o`  out  2×WIDTH  {remainder[2W-1:W], quotient[W-1:0]}.
- `ready_o`  out  1  `result_o` valid.

## Operation
- FSM states: `DivFree`, `DivByZero`, `DivOn`, `DivEnd`.
- **`DivFree`**: `ready_o`=0 and `result_o`=0.
  - If `start_i`=1 and `annul_i`=0: if the divisor is 0, go to `DivByZero`; otherwise go to `DivOn`.
  - On entry to `DivOn`: `cnt`=0 and `work`(2W+1 bits) = {W'b0, |dividend|, 1'b0}. Absolute values are taken only in signed mode.
- **`DivOn`**, while `cnt` < W, one restoring step per edge:
  - `diff` = {1'b0, `work`[2W-1:W]} − {1'b0, |divisor|}.
  - If `diff`[W]=1 (negative): `work` = {`work`[2W-1:0], 1'b0}.
  - Otherwise: `work` = {`diff`[W-1:0], `work`[W-1:0], 1'b1}.
  - Then `cnt`++.
- **`DivOn`**, when `cnt`=W: finalize and go to `DivEnd`.
  - Raw quotient = `work`[W-1:0]; raw remainder = `work`[2W:W+1].
  - Signed mode: negate the quotient if the operand signs differ; negate the remainder if the dividend is negative.
  - Load `result_o` and set `ready_o`=1.
- **`DivByZero`**: next edge goes to `DivEnd` with `result_o`=0 and `ready_o`=1.
- **`DivEnd`**: hold `result_o` and `ready_o`=1 while `start_i`=1. When `start_i`=0, go to `DivFree` on the next edge and clear `ready_o` and `result_o` there.
- `annul_i`=1 in any state: go to `DivFree` on the next edge with outputs cleared. `annul_i` has priority over `start_i` and over finalize.
- `start_i` dropping during `DivOn` (without annul) is ignored; the operation completes.
- Operand changes after acceptance are ignored; operands are captured only on the `DivFree` → `DivOn` edge.
- Arithmetic wraps modulo 2^W.
  - 0x80000000 / 0xFFFFFFFF (signed) gives quotient 0x80000000, remainder 0.
- EX stall request = `start_i` & ~`ready_o` (formed in EX, not here).

## Timing
- Reset (`rst`=0, asynchronous): state `DivFree`, `cnt`=0, `work`=0, `ready_o`=0, `result_o`=0. This applies immediately, including mid-operation.
- Edge numbering: the acceptance edge is E0.
- Normal division: iterations on E1..EW, finalize on E(W+1). `ready_o` is high in the cycle after E(W+1), i.e. 33 cycles after acceptance for W=32.
- Divide by zero: `ready_o` is high after E1.
- Back-to-back operations: at least one cycle in `DivFree` between operations (`start_i` must drop).
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `DIV_SIGNED_EN` defined: signed handling as above (absolute values plus sign correction).
- `DIV_SIGNED_EN` undefined:
  - `signed_div_i` is ignored; all operations are unsigned.
  - Absolute-value and sign-correction logic is not built.
  - The signed test vectors below produce unsigned results.

## Structure
- `defines.v` gets:
  - state encodings `DivFree`/`DivByZero`/`DivOn`/`DivEnd` (2 bits).
  - `DivResultReady`/`DivResultNotReady`, `DivStart`/`DivStop`.
  - `DivWidth`=32.
- Single module; no sub-module. The restoring step is an inline subtract.

## Test plan
- Unsigned 100/7, `start_i` held → `ready_o` rises exactly 33 cycles after acceptance; `result_o` = {0x00000002, 0x0000000E}.
- Signed −7/2 (0xFFFFFFF9 / 0x00000002) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 0x80000000 / 0xFFFFFFFF → {0, 0x80000000}.
- Divisor 0 → `ready_o` high after 2 edges; `result_o`=0.
- `annul_i` pulsed at iteration 10 → `DivFree` on the next edge; `ready_o` never rises. A new start then gives a correct result (0xFFFFFFFF/1 → {0, 0xFFFFFFFF}).
- `rst` asserted asynchronously mid-`DivOn` → outputs 0 immediately. After release, a new division completes normally.
- In `DivEnd`, keep `start_i`=1 for 5 cycles → result held steady. Drop `start_i` → `ready_o`=0 and `result_o`=0 after one edge.
